// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions used by the decode/execute boundary.
//   XLEN      datapath width
//   REG_AW    architectural register index width
//   alu_func_e  4-bit ALU function encoding, common to decode, ID/EX and ALU
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // ALU function codes. SUB, SRA and SRAI reuse the ADD/SRL/SRLI codes and are
    // distinguished by the separate sub_sra select bit.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,   // ADD / SUB
        ALU_XOR  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_SLLI = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,   // SRL / SRA
        ALU_SRLI = 4'b0111,   // SRLI / SRAI
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_func_e;

endpackage : rv32i_pkg

// File: rtl/operand_fwd_mux.sv
// -----------------------------------------------------------------------------
// operand_fwd_mux
// Resolves one source operand against the two in-flight writers.
//   rs_addr      source register index
//   rf_data      register file read data for rs_addr
//   exm_*        EX/MEM writer (youngest, wins over MEM/WB)
//   wb_*         MEM/WB writer
//   fwd_data     resolved operand value
// x0 is hardwired to zero in the register file, so it is never forwarded even
// when a writer names it as destination.
// With FWD_EN=0 the register file data passes straight through.
// -----------------------------------------------------------------------------
module operand_fwd_mux #(
    parameter int XLEN   = rv32i_pkg::XLEN,
    parameter int REG_AW = rv32i_pkg::REG_AW,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic              exm_rd_we,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   fwd_data
);

    generate
        if (FWD_EN) begin : g_fwd
            logic rs_nonzero_s;
            logic exm_hit_s;
            logic wb_hit_s;

            assign rs_nonzero_s = (rs_addr != {REG_AW{1'b0}});
            assign exm_hit_s    = rs_nonzero_s & exm_rd_we & (exm_rd_addr == rs_addr);
            assign wb_hit_s     = rs_nonzero_s & wb_rd_we  & (wb_rd_addr  == rs_addr);

            // Priority select: the EX/MEM result is newer than the MEM/WB one
            always_comb begin
                fwd_data = rf_data;
                if (exm_hit_s) begin
                    fwd_data = exm_result;
                end else if (wb_hit_s) begin
                    fwd_data = wb_result;
                end else begin
                    fwd_data = rf_data;
                end
            end
        end else begin : g_nofwd
            assign fwd_data = rf_data;
        end
    endgenerate

endmodule : operand_fwd_mux

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register in front of the RV32I ALU. Captures one decoded
// instruction per accepted handshake, resolves RAW hazards by forwarding from
// EX/MEM and MEM/WB, and presents registered operands and control to the ALU.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   flush                         drop held entry and this cycle's input
//   in_valid / in_ready           decode-side handshake
//   in_rs1/rs2_addr, _data        source indices and register file data
//   in_imm, in_pc                 immediate and instruction PC
//   in_use_imm, in_use_pc         B = imm, A = pc selects
//   in_func, in_sub_sra           ALU function and SUB/SRA select
//   in_rd_addr, in_rd_we          destination
//   exm_*, wb_*                   forwarding sources (EX/MEM, MEM/WB)
//   out_valid / out_ready         execute-side handshake
//   alu_a, alu_b, alu_shamt       registered operands, shamt = imm[4:0]
//   alu_func, alu_sub_sra         registered ALU control
//   out_rd_addr, out_rd_we        registered destination, we gated by valid
//
// While an entry is held by back-pressure, a MEM/WB write to one of its
// register-sourced operands reloads that operand, so a stalled instruction
// never leaves with a value that has since been retired to the register file.
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int XLEN   = rv32i_pkg::XLEN,
    parameter int REG_AW = rv32i_pkg::REG_AW,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              in_use_imm,
    input  logic              in_use_pc,
    input  logic [3:0]        in_func,
    input  logic              in_sub_sra,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_rd_we,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic              exm_rd_we,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_func,
    output logic              alu_sub_sra,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_rd_we
);

    import rv32i_pkg::*;

    // Handshake / valid state
    logic              out_valid_r;
    logic              rd_we_r;
    logic              valid_next_s;
    logic              capture_s;
    logic              hold_s;

    // Payload bank
    logic [XLEN-1:0]   alu_a_r;
    logic [XLEN-1:0]   alu_b_r;
    logic [4:0]        alu_shamt_r;
    logic [3:0]        alu_func_r;
    logic              alu_sub_sra_r;
    logic [REG_AW-1:0] rd_addr_r;

    // Source bookkeeping for the hold-time refresh
    logic [REG_AW-1:0] rs1_addr_r;
    logic [REG_AW-1:0] rs2_addr_r;
    logic              a_is_reg_r;
    logic              b_is_reg_r;

    logic [XLEN-1:0]   rs1_fwd_s;
    logic [XLEN-1:0]   rs2_fwd_s;
    logic [XLEN-1:0]   a_next_s;
    logic [XLEN-1:0]   b_next_s;
    logic              wb_live_s;
    logic              refresh_a_s;
    logic              refresh_b_s;

    // Ready depends only on our own occupancy and downstream, never on in_valid
    assign in_ready  = ~out_valid_r | out_ready;
    assign capture_s = in_valid & in_ready & ~flush;
    assign hold_s    = out_valid_r & ~out_ready;

    // Next-valid: flush wins, otherwise refill when the slot frees up
    always_comb begin
        valid_next_s = out_valid_r;
        if (flush) begin
            valid_next_s = 1'b0;
        end else if (in_ready) begin
            valid_next_s = in_valid;
        end else begin
            valid_next_s = out_valid_r;
        end
    end

    operand_fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .FWD_EN (FWD_EN)
    ) u_fwd_rs1 (
        .rs_addr     (in_rs1_addr),
        .rf_data     (in_rs1_data),
        .exm_rd_addr (exm_rd_addr),
        .exm_rd_we   (exm_rd_we),
        .exm_result  (exm_result),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .wb_result   (wb_result),
        .fwd_data    (rs1_fwd_s)
    );

    operand_fwd_mux #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .FWD_EN (FWD_EN)
    ) u_fwd_rs2 (
        .rs_addr     (in_rs2_addr),
        .rf_data     (in_rs2_data),
        .exm_rd_addr (exm_rd_addr),
        .exm_rd_we   (exm_rd_we),
        .exm_result  (exm_result),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .wb_result   (wb_result),
        .fwd_data    (rs2_fwd_s)
    );

    // Operand source select for a newly captured instruction
    always_comb begin
        a_next_s = rs1_fwd_s;
        b_next_s = rs2_fwd_s;
        if (in_use_pc) begin
            a_next_s = in_pc;
        end else begin
            a_next_s = rs1_fwd_s;
        end
        if (in_use_imm) begin
            b_next_s = in_imm;
        end else begin
            b_next_s = rs2_fwd_s;
        end
    end

    // A retiring write to x0 carries no architectural value, so it never refreshes
    assign wb_live_s   = FWD_EN & wb_rd_we & (wb_rd_addr != {REG_AW{1'b0}});
    assign refresh_a_s = hold_s & wb_live_s & a_is_reg_r & (wb_rd_addr == rs1_addr_r);
    assign refresh_b_s = hold_s & wb_live_s & b_is_reg_r & (wb_rd_addr == rs2_addr_r);

    // Valid flop and the valid-gated write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            rd_we_r     <= 1'b0;
        end else begin
            out_valid_r <= valid_next_s;
            rd_we_r     <= valid_next_s & (capture_s ? in_rd_we : rd_we_r);
        end
    end

    // Payload bank: load on capture, otherwise hold with per-operand refresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r       <= {XLEN{1'b0}};
            alu_b_r       <= {XLEN{1'b0}};
            alu_shamt_r   <= 5'd0;
            alu_func_r    <= ALU_ADD;
            alu_sub_sra_r <= 1'b0;
            rd_addr_r     <= {REG_AW{1'b0}};
            rs1_addr_r    <= {REG_AW{1'b0}};
            rs2_addr_r    <= {REG_AW{1'b0}};
            a_is_reg_r    <= 1'b0;
            b_is_reg_r    <= 1'b0;
        end else if (capture_s) begin
            alu_a_r       <= a_next_s;
            alu_b_r       <= b_next_s;
            alu_shamt_r   <= in_imm[4:0];
            alu_func_r    <= in_func;
            alu_sub_sra_r <= in_sub_sra;
            rd_addr_r     <= in_rd_addr;
            rs1_addr_r    <= in_rs1_addr;
            rs2_addr_r    <= in_rs2_addr;
            a_is_reg_r    <= ~in_use_pc;
            b_is_reg_r    <= ~in_use_imm;
        end else begin
            if (refresh_a_s) begin
                alu_a_r <= wb_result;
            end
            if (refresh_b_s) begin
                alu_b_r <= wb_result;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign out_rd_we   = rd_we_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_shamt   = alu_shamt_r;
    assign alu_func    = alu_func_r;
    assign alu_sub_sra = alu_sub_sra_r;
    assign out_rd_addr = rd_addr_r;

endmodule : id_ex_operand_stage

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of the stage (one expected entry, updated per cycle).
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_use_imm, in_use_pc, in_sub_sra, in_rd_we;
    logic [3:0]  in_func;
    logic [4:0]  exm_rd_addr, wb_rd_addr;
    logic        exm_rd_we, wb_rd_we;
    logic [31:0] exm_result, wb_result;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_func;
    logic        alu_sub_sra;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .in_func(in_func), .in_sub_sra(in_sub_sra),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .exm_rd_addr(exm_rd_addr), .exm_rd_we(exm_rd_we), .exm_result(exm_result),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_result(wb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_func(alu_func), .alu_sub_sra(alu_sub_sra),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
    );

    // Expected content of the stage as one abstract instruction record
    typedef struct {
        bit          v;
        logic [31:0] a, b;
        logic [4:0]  shamt, rd, rs1, rs2;
        logic [3:0]  func;
        bit          sub, we, a_reg, b_reg;
    } entry_t;

    entry_t m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a source register holds as seen by the instruction being decoded
    function automatic logic [31:0] arch_value(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (exm_rd_we && exm_rd_addr == rs) return exm_result;
        if (wb_rd_we && wb_rd_addr == rs) return wb_result;
        return rf;
    endfunction

    task automatic model_reset();
        m = '{v: 1'b0, a: 32'd0, b: 32'd0, shamt: 5'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
              func: 4'd0, sub: 1'b0, we: 1'b0, a_reg: 1'b0, b_reg: 1'b0};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_a"}, alu_a, 32'd0);
        check({tag, "_b"}, alu_b, 32'd0);
        check({tag, "_shamt"}, {27'd0, alu_shamt}, 32'd0);
        check({tag, "_func"}, {28'd0, alu_func}, 32'd0);
        check({tag, "_subsra"}, {31'd0, alu_sub_sra}, 32'd0);
        check({tag, "_rd"}, {27'd0, out_rd_addr}, 32'd0);
        check({tag, "_rdwe"}, {31'd0, out_rd_we}, 32'd0);
    endtask

    task automatic check_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, m.v});
        check("out_rd_we", {31'd0, out_rd_we}, {31'd0, m.v & m.we});
        if (m.v) begin
            check("alu_a", alu_a, m.a);
            check("alu_b", alu_b, m.b);
            check("alu_shamt", {27'd0, alu_shamt}, {27'd0, m.shamt});
            check("alu_func", {28'd0, alu_func}, {28'd0, m.func});
            check("alu_sub_sra", {31'd0, alu_sub_sra}, {31'd0, m.sub});
            check("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, m.rd});
        end
    endtask

    // One clock: predict next entry from current inputs, clock, compare
    task automatic cycle();
        entry_t n;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m.v) | out_ready});
        n = m;
        if (flush) begin
            n.v = 1'b0;
        end else if (!m.v || out_ready) begin
            if (in_valid) begin
                n.v     = 1'b1;
                n.a     = in_use_pc  ? in_pc  : arch_value(in_rs1_addr, in_rs1_data);
                n.b     = in_use_imm ? in_imm : arch_value(in_rs2_addr, in_rs2_data);
                n.shamt = in_imm[4:0];
                n.func  = in_func;
                n.sub   = in_sub_sra;
                n.rd    = in_rd_addr;
                n.we    = in_rd_we;
                n.rs1   = in_rs1_addr;
                n.rs2   = in_rs2_addr;
                n.a_reg = !in_use_pc;
                n.b_reg = !in_use_imm;
            end else begin
                n.v = 1'b0;
            end
        end else if (wb_rd_we && wb_rd_addr != 5'd0) begin
            if (m.a_reg && wb_rd_addr == m.rs1) n.a = wb_result;
            if (m.b_reg && wb_rd_addr == m.rs2) n.b = wb_result;
        end
        @(posedge clk);
        #1;
        m = n;
        check_outputs();
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic uimm, input logic upc,
                             input logic [3:0] func, input logic sub,
                             input logic [4:0] rd, input logic we);
        in_rs1_addr = rs1; in_rs2_addr = rs2;
        in_rs1_data = d1;  in_rs2_data = d2;
        in_imm = imm; in_pc = pc;
        in_use_imm = uimm; in_use_pc = upc;
        in_func = func; in_sub_sra = sub;
        in_rd_addr = rd; in_rd_we = we;
    endtask

    task automatic no_fwd();
        exm_rd_we = 1'b0; exm_rd_addr = 5'd0; exm_result = 32'd0;
        wb_rd_we  = 1'b0; wb_rd_addr  = 5'd0; wb_result  = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_instr(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0);
        no_fwd();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back ADD x3=x1+x2 ; ADD x4=x3+x3 forwarded from EX/MEM
        in_valid = 1'b1;
        set_instr(5'd1, 5'd2, 32'h111, 32'h222, 32'd0, 32'h100, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd3, 1'b1);
        cycle();
        check("add1_a", alu_a, 32'h111);
        set_instr(5'd3, 5'd3, 32'hDEAD, 32'hBEEF, 32'd0, 32'h104, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd4, 1'b1);
        exm_rd_we = 1'b1; exm_rd_addr = 5'd3; exm_result = 32'h10;
        cycle();
        check("b2b_a", alu_a, 32'h10);
        check("b2b_b", alu_b, 32'h10);

        // EX/MEM beats MEM/WB on the same register
        set_instr(5'd5, 5'd6, 32'h5555, 32'h6666, 32'd0, 32'h108, 1'b0, 1'b0, 4'b0001, 1'b0, 5'd9, 1'b1);
        exm_rd_addr = 5'd5; exm_result = 32'hAAAA;
        wb_rd_we = 1'b1; wb_rd_addr = 5'd5; wb_result = 32'hBBBB;
        cycle();
        check("prio_a", alu_a, 32'hAAAA);
        check("prio_b", alu_b, 32'h6666);

        // x0 never forwarded
        set_instr(5'd0, 5'd0, 32'h1234, 32'h0, 32'd0, 32'h10C, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd10, 1'b1);
        exm_rd_addr = 5'd0; exm_result = 32'h999;
        wb_rd_addr = 5'd0; wb_result = 32'h777;
        cycle();
        check("x0_a", alu_a, 32'h1234);
        no_fwd();

        // Stall three cycles with MEM/WB refreshing the held rs2 operand
        set_instr(5'd1, 5'd7, 32'h11, 32'h77, 32'd0, 32'h110, 1'b0, 1'b0, 4'b0011, 1'b0, 5'd8, 1'b1);
        cycle();
        out_ready = 1'b0;
        set_instr(5'd2, 5'd3, 32'h22, 32'h33, 32'd0, 32'h114, 1'b0, 1'b0, 4'b0010, 1'b0, 5'd9, 1'b1);
        cycle();
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_rd", {27'd0, out_rd_addr}, 32'd8);
        wb_rd_we = 1'b1; wb_rd_addr = 5'd7; wb_result = 32'h55;
        cycle();
        check("refresh_b", alu_b, 32'h55);
        check("refresh_a_kept", alu_a, 32'h11);
        no_fwd();
        cycle();
        out_ready = 1'b1;
        cycle();
        check("after_hold_rd", {27'd0, out_rd_addr}, 32'd9);

        // Flush while holding, with new input present
        out_ready = 1'b0;
        set_instr(5'd4, 5'd5, 32'h44, 32'h45, 32'd0, 32'h118, 1'b0, 1'b0, 4'b0000, 1'b1, 5'd11, 1'b1);
        cycle();
        flush = 1'b1;
        cycle();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_rdwe", {31'd0, out_rd_we}, 32'd0);
        flush = 1'b0; out_ready = 1'b1;
        set_instr(5'd6, 5'd7, 32'h66, 32'h67, 32'd0, 32'h11C, 1'b0, 1'b0, 4'b1000, 1'b0, 5'd12, 1'b1);
        cycle();
        check("post_flush_rd", {27'd0, out_rd_addr}, 32'd12);

        // AUIPC, then SRAI
        set_instr(5'd0, 5'd0, 32'h0, 32'h0, 32'h2000, 32'h1000, 1'b1, 1'b1, 4'b0000, 1'b0, 5'd13, 1'b1);
        cycle();
        check("auipc_a", alu_a, 32'h1000);
        check("auipc_b", alu_b, 32'h2000);
        check("auipc_func", {28'd0, alu_func}, 32'd0);
        set_instr(5'd1, 5'd0, 32'h8000_0000, 32'h0, 32'h405, 32'h1004, 1'b1, 1'b0, 4'b0111, 1'b1, 5'd14, 1'b1);
        cycle();
        check("srai_shamt", {27'd0, alu_shamt}, 32'd5);
        check("srai_sub", {31'd0, alu_sub_sra}, 32'd1);

        // Idle cycle empties the stage
        in_valid = 1'b0;
        cycle();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // Randomized traffic with small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            exm_rd_we = 1'($urandom_range(0, 1)); exm_rd_addr = 5'($urandom_range(0, 7));
            exm_result = $urandom;
            wb_rd_we = 1'($urandom_range(0, 1)); wb_rd_addr = 5'($urandom_range(0, 7));
            wb_result = $urandom;
            cycle();
        end

        // Asynchronous reset with a live entry
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; no_fwd();
        set_instr(5'd1, 5'd2, 32'hCAFE, 32'hF00D, 32'h1F, 32'h200, 1'b0, 1'b0, 4'b0101, 1'b1, 5'd15, 1'b1);
        cycle();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        check("recover_a", alu_a, 32'hCAFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_id_ex_operand_stage
